// File: rtl/dpb_port_arbiter.sv
// dpb_port_arbiter: two-requester round-robin arbiter and sequencer for
// port A of a 2^AW x DW dual-port block RAM. Requests are granted at most
// one per cycle. Read ids travel through a tag pipeline that matches the
// RAM read latency, so read data is steered back to the requester that
// issued it. RD_LAT must be 1 (bypass) or 2 (output-register mode).
module dpb_port_arbiter #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    // requester 0
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    // requester 1
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    // responses
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    // RAM port A
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_we,
    output logic          ram_reset,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic              prio;      // favoured requester for a tie
    logic              gnt0;
    logic              gnt1;
    logic              rd_acc;    // a read is accepted this cycle
    logic [RD_LAT:1]   vld_pipe;  // tag stage valid bits
    logic [RD_LAT:1]   id_pipe;   // tag stage requester ids
    logic              rsp_fire;

    // Grant decision: a lone requester wins, a tie goes to prio, nothing
    // is granted while reset is held.
    always_comb begin
        gnt0 = !reset && req0_valid && (!req1_valid || !prio);
        gnt1 = !reset && req1_valid && (!req0_valid || prio);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // RAM port A drive: granted request fields, zeros when idle.
    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        rd_acc   = 1'b0;
        if (gnt0) begin
            ram_ce   = 1'b1;
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_din  = req0_wdata;
            rd_acc   = !req0_we;
        end else if (gnt1) begin
            ram_ce   = 1'b1;
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
            rd_acc   = !req1_we;
        end
    end

    // Output register of the RAM is always enabled; its reset follows ours.
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

    // Round-robin pointer: after a grant the other requester is favoured.
    always_ff @(posedge clk) begin
        if (reset)
            prio <= 1'b0;
        else if (gnt0)
            prio <= 1'b1;
        else if (gnt1)
            prio <= 1'b0;
    end

    // Tag pipeline, one stage per cycle of RAM read latency; reset drops
    // every in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            id_pipe[1]  <= gnt1;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // Response steering: the last stage selects which requester sees the
    // RAM output this cycle. Gated by reset so a tag caught by reset never
    // surfaces.
    assign rsp_fire   = vld_pipe[RD_LAT] && !reset;
    assign rsp0_valid = rsp_fire && !id_pipe[RD_LAT];
    assign rsp1_valid = rsp_fire &&  id_pipe[RD_LAT];
    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;

endmodule
